gcd_operand_feeder: RTL

- Upstream stage of the GCD unit: accepts (a, b) operand pairs through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Presents each pair to the GCD input port as one packed 32-bit word, {x, y}. The GCD unit loads x from bits [31:16] and y from bits [15:0], and returns its result from y.
- Sanitizes each pair on write so the GCD never receives y == 0 with x != 0. That case does not terminate in the subtract loop.
- Decouples the operand producer from GCD busy periods.

---
 rtl/gcd_operand_feeder.sv | 83 ++++++++
 1 files changed

// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: buffers (a, b) operand pairs in a small FIFO ahead of
// the GCD unit and presents each one as a packed {x, y} word. A pair with
// b == 0 is rewritten to {0, a} on the way in so the GCD never sees y == 0
// with x != 0, which would never finish in its subtract loop.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both 1. A producer holds valid and its data until that edge. The feeder
// holds out_data stable while out_valid is 1 until the pop edge. in_ready and
// out_valid come from registered occupancy only, with no combinational path
// from out_ready or in_valid.
module gcd_operand_feeder #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [2*WIDTH-1:0]         out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 fixups
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [2*WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic               b_zero;
    logic [2*WIDTH-1:0] sanitized;

    // Handshake qualifiers and the sanitized entry for the current input.
    always_comb begin
        in_ready  = (count != FULL);
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        b_zero    = (in_b == '0);
        sanitized = b_zero ? {{WIDTH{1'b0}}, in_a} : {in_a, in_b};
        out_data  = storage[rd_ptr];
    end

    // Storage is written on push only; it is not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            storage[wr_ptr] <= sanitized;
        end
    end

    // Pointers, occupancy and the saturating fixup counter; reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fixups <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (push && b_zero && fixups != 8'hFF) begin
                fixups <= fixups + 8'd1;
            end
        end
    end

endmodule
